phy_tx_sched: RTL and testbench
===============================

Name: phy_tx_sched

Overview:
- Transmit-side scheduler in front of the phy serializer.
- Brings the link up by sending COM training words, then shares one 9-bit phy transmit lane among four upstream requesters.
- Arbitration is round-robin with a per-lane burst cap; idle words are inserted when no requester is ready.
- Sits between the four lane FIFOs (pop handshake) and the phy_tx parallel input. Uses the rx-side lock indication as link_ok.

Parameters:
- COM, 8'hBC, training/comma symbol.
- IDLE, 8'h7C, filler symbol sent when no lane requests.
- TRAIN_LEN, 4, minimum COM words sent before ACTIVE is allowed (>=1).
- MAX_BURST, 4, maximum consecutive grants to one lane while another lane requests (>=1).

Ports:
- clk  in  1  single clock (phy parallel-word rate); all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req  in  4  bit i = lane i FIFO non-empty.
- data_in0  in  8  lane 0 head word.
- data_in1  in  8  lane 1 head word.
- data_in2  in  8  lane 2 head word.
- data_in3  in  8  lane 3 head word.
- link_ok  in  1  rx locked on COM.
- pop  out  4  one-hot or zero; pops the granted lane FIFO this cycle.
- tx_word  out  9  registered; [8] valid, [7:0] symbol; drives the phy parallel input.
- tx_lane_id  out  2  registered; lane carried in tx_word.
- state  out  2  registered; 0 RESET, 1 TRAIN, 2 ACTIVE.

Behaviour:
- Reset (async, reset_L=0):
  - state=RESET, tx_word=9'h000, tx_lane_id=0.
  - Round-robin pointer=0, burst_cnt=0, com_cnt=0.
  - pop=0 throughout reset.
  - Takes effect immediately, including mid-burst or mid-train.
- RESET -> TRAIN at the first clock edge after reset_L rises. tx_word is still 0 on that edge.
- TRAIN:
  - Each edge loads tx_word={1,COM} and increments com_cnt (saturating at TRAIN_LEN).
  - pop=0.
  - Go to ACTIVE on the edge where com_cnt==TRAIN_LEN-1 and link_ok=1, i.e. after at least TRAIN_LEN COM words have been issued.
  - If link_ok=0, stay in TRAIN indefinitely.
- ACTIVE, pop:
  - pop is combinational from registered state and current req (Mealy).
  - The popped data is registered into tx_word at the same edge: one-cycle latency, tx_word={1,data_in[g]}, tx_lane_id=g.
- ACTIVE, no request (req==0): pop=0, tx_word={0,IDLE}, tx_lane_id holds, pointer and burst_cnt hold.
- ACTIVE, grant selection:
  - Let last = previously granted lane.
  - If req[last] and (burst_cnt<MAX_BURST or no other lane requests): grant last; burst_cnt=min(burst_cnt+1, MAX_BURST).
  - Else grant the first requesting lane searching last+1, last+2, ... mod 4; burst_cnt=1.
  - Exactly one lane is granted per cycle.
- ACTIVE -> TRAIN when link_ok=0 is sampled at the edge:
  - pop=0 that cycle and tx_word={1,COM}.
  - com_cnt restarts at 1; burst_cnt=0; pointer keeps its value.
  - No data word is lost.
- Simultaneous link_ok=0 and req in ACTIVE: link loss wins; no pop.
- state encoding 3 is unused; if reached, go to RESET behaviour on the next edge.

Decomposition:
- Shared package phy_pkg:
  - COM/IDLE defaults.
  - State encodings ST_RESET/ST_TRAIN/ST_ACTIVE.
  - Valid-bit index (8) and lane count (4).
- One sub-module: rr_pick4, a combinational round-robin picker.
  - Inputs: req[3:0], start[1:0].
  - Outputs: gnt one-hot, gnt_id, any.
- phy_tx_sched instantiates rr_pick4 with start=last+1 and applies the burst-hold override itself.

Test Plan:
1. Release reset, link_ok=1, req=0 -> state 1 for 4 cycles with tx_word=0x1BC each; then state 2, tx_word=0x07C, pop=0.
2. link_ok=0 held for 50 cycles after reset -> state stays 1, tx_word=0x1BC every cycle, pop never asserted.
3. ACTIVE, req=4'b1111 continuously, data_in0..3=0x10..0x13 -> tx_lane_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; tx_word 0x110 x4, 0x111 x4, and so on.
4. ACTIVE, only req[2]=1 for 10 cycles, data_in2=0xA5 -> pop=4'b0100 all 10 cycles, tx_word=0x1A5 continuously, no IDLE; the cap is not applied.
5. ACTIVE mid-burst on lane1 (2nd grant), link_ok drops for 1 cycle -> that cycle pop=0, next tx_word=0x1BC, state=1; link_ok back -> 4 COM words, then ACTIVE, arbitration resumes from lane1 or later.
6. reset_L pulsed low between clock edges during ACTIVE -> tx_word=0, state=0, pop=0 immediately (before the next edge); recovery as in scenario 1.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared definitions for the phy transmit scheduler: symbols, state codes,
// word layout and lane count.
package phy_pkg;

   localparam int LANES     = 4;
   localparam int VALID_BIT = 8;

   localparam logic [7:0] COM_DEF  = 8'hBC;
   localparam logic [7:0] IDLE_DEF = 8'h7C;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_TRAIN  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_BAD    = 2'd3
   } state_e;

   // Build a phy parallel word from a valid flag and a symbol.
   function automatic logic [VALID_BIT:0] mk_word(input logic v, input logic [7:0] s);
      logic [VALID_BIT:0] w;
      w                  = '0;
      w[VALID_BIT]       = v;
      w[VALID_BIT-1:0]   = s;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting lane at or after start,
// wrapping modulo four.
module rr_pick4
   import phy_pkg::*;
(
   input  logic [LANES-1:0] req,
   input  logic [1:0]       start,
   output logic [LANES-1:0] gnt,
   output logic [1:0]       gnt_id,
   output logic             any
);

   // Walk the four lanes starting at start and take the first requester.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         logic [1:0] idx;
         idx = start + 2'(k);
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phy_tx_sched.sv
// Transmit scheduler: trains the link with COM words, then shares one 9-bit
// phy lane among four lane FIFOs using round-robin with a per-lane burst cap.
module phy_tx_sched
   import phy_pkg::*;
#(
   parameter logic [7:0] COM       = COM_DEF,
   parameter logic [7:0] IDLE      = IDLE_DEF,
   parameter int         TRAIN_LEN = 4,
   parameter int         MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [LANES-1:0]  req,
   input  logic [7:0]        data_in0,
   input  logic [7:0]        data_in1,
   input  logic [7:0]        data_in2,
   input  logic [7:0]        data_in3,
   input  logic              link_ok,
   output logic [LANES-1:0]  pop,
   output logic [8:0]        tx_word,
   output logic [1:0]        tx_lane_id,
   output logic [1:0]        state
);

   localparam int CW = $clog2(TRAIN_LEN + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   com_cnt_q, com_cnt_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [1:0]      last_q, last_d;
   logic [8:0]      tx_word_q, tx_word_d;
   logic [1:0]      lane_q, lane_d;

   logic [7:0]       lane_data [LANES];
   logic [LANES-1:0] rr_gnt;
   logic [1:0]       rr_id;
   logic             rr_any;
   logic             others_req;
   logic             hold;
   logic             gnt_vld;
   logic [1:0]       gnt_id;

   assign lane_data[0] = data_in0;
   assign lane_data[1] = data_in1;
   assign lane_data[2] = data_in2;
   assign lane_data[3] = data_in3;

   // Search starts just after the last granted lane; burst hold is decided here.
   rr_pick4 u_pick (
      .req    (req),
      .start  (last_q + 2'd1),
      .gnt    (rr_gnt),
      .gnt_id (rr_id),
      .any    (rr_any)
   );

   // Grant decision: stay on the last lane while under the cap or uncontested.
   always_comb begin
      others_req = |(req & ~(4'b0001 << last_q));
      hold       = req[last_q] && ((burst_q < BW'(MAX_BURST)) || !others_req);
      gnt_vld    = (state_q == ST_ACTIVE) && link_ok && rr_any;
      gnt_id     = hold ? last_q : rr_id;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; ACTIVE needs enough COM words and a locked receiver.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_TRAIN;
         ST_TRAIN:  if (link_ok && (com_cnt_q >= CW'(TRAIN_LEN - 1))) state_d = ST_ACTIVE;
         ST_ACTIVE: if (!link_ok) state_d = ST_TRAIN;
         default:   state_d = ST_RESET;
      endcase
   end

   // FIFO pop strobe, Mealy on registered state and live request.
   always_comb begin
      pop = '0;
      if (gnt_vld) begin
         pop = 4'b0001 << gnt_id;
      end
   end

   // Datapath next values: training words, popped data, idle fill, counters.
   always_comb begin
      tx_word_d = tx_word_q;
      lane_d    = lane_q;
      com_cnt_d = com_cnt_q;
      burst_d   = burst_q;
      last_d    = last_q;
      case (state_q)
         ST_RESET: begin
            tx_word_d = '0;
            com_cnt_d = '0;
         end
         ST_TRAIN: begin
            tx_word_d = mk_word(1'b1, COM);
            if (com_cnt_q < CW'(TRAIN_LEN)) begin
               com_cnt_d = com_cnt_q + CW'(1);
            end
         end
         ST_ACTIVE: begin
            if (!link_ok) begin
               // Link loss wins over any request; this COM counts as the first.
               tx_word_d = mk_word(1'b1, COM);
               com_cnt_d = CW'(1);
               burst_d   = '0;
            end else if (gnt_vld) begin
               tx_word_d = mk_word(1'b1, lane_data[gnt_id]);
               lane_d    = gnt_id;
               last_d    = gnt_id;
               if (hold) begin
                  burst_d = (burst_q >= BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
               end else begin
                  burst_d = BW'(1);
               end
            end else begin
               tx_word_d = mk_word(1'b0, IDLE);
            end
         end
         default: begin
            tx_word_d = '0;
            lane_d    = '0;
            com_cnt_d = '0;
            burst_d   = '0;
            last_d    = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         tx_word_q <= '0;
         lane_q    <= '0;
         com_cnt_q <= '0;
         burst_q   <= '0;
         last_q    <= '0;
      end else begin
         tx_word_q <= tx_word_d;
         lane_q    <= lane_d;
         com_cnt_q <= com_cnt_d;
         burst_q   <= burst_d;
         last_q    <= last_d;
      end
   end

   assign tx_word    = tx_word_q;
   assign tx_lane_id = lane_q;
   assign state      = state_q;

   logic unused_ok;
   assign unused_ok = ^rr_gnt;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Scoreboard bench for phy_tx_sched: each driven cycle pushes the expected
// registered word/lane/state, popped and compared after the clock edge.
module tb_phy_tx_sched;

   logic       clk;
   logic       reset_L;
   logic [3:0] req;
   logic [7:0] data_in0, data_in1, data_in2, data_in3;
   logic       link_ok;
   logic [3:0] pop;
   logic [8:0] tx_word;
   logic [1:0] tx_lane_id;
   logic [1:0] state;

   int n_chk  = 0;
   int n_pass = 0;
   int n_cyc  = 0;

   typedef struct packed {
      logic [8:0] w;
      logic [1:0] l;
      logic [1:0] s;
   } exp_t;

   exp_t sbq[$];

   phy_tx_sched dut (
      .clk        (clk),
      .reset_L    (reset_L),
      .req        (req),
      .data_in0   (data_in0),
      .data_in1   (data_in1),
      .data_in2   (data_in2),
      .data_in3   (data_in3),
      .link_ok    (link_ok),
      .pop        (pop),
      .tx_word    (tx_word),
      .tx_lane_id (tx_lane_id),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One clock of stimulus: check pop, queue expected result, compare after edge.
   task automatic cyc(input logic [3:0] r, input logic lk, input logic [8:0] ew,
                      input logic [1:0] el, input logic [3:0] ep, input logic [1:0] es);
      exp_t e;
      exp_t got;
      req     = r;
      link_ok = lk;
      #1;
      chk("pop", {28'd0, pop}, {28'd0, ep});
      e.w = ew;
      e.l = el;
      e.s = es;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      n_cyc++;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         got = sbq.pop_front();
         chk("tx_word", {23'd0, tx_word}, {23'd0, got.w});
         chk("tx_lane_id", {30'd0, tx_lane_id}, {30'd0, got.l});
         chk("state", {30'd0, state}, {30'd0, got.s});
         $display("cyc %0d req=%b link=%b pop=%b tx=%h lane=%0d st=%0d",
                  n_cyc, r, lk, ep, tx_word, tx_lane_id, state);
      end
   endtask

   // Bring-up after reset release with link_ok=1: one RESET edge, four COMs.
   task automatic train_up(input logic [3:0] r, input logic [1:0] el);
      cyc(r, 1'b1, 9'h000, el, 4'h0, 2'd1);
      for (int i = 0; i < 3; i++) cyc(r, 1'b1, 9'h1BC, el, 4'h0, 2'd1);
      cyc(r, 1'b1, 9'h1BC, el, 4'h0, 2'd2);
   endtask

   function automatic logic [8:0] dw(input int l);
      logic [7:0] d;
      d = 8'(8'h10 + l);
      return {1'b1, d};
   endfunction

   initial begin
      int l;
      reset_L  = 1'b0;
      link_ok  = 1'b1;
      req      = 4'hF;
      data_in0 = 8'h10;
      data_in1 = 8'h11;
      data_in2 = 8'h12;
      data_in3 = 8'h13;

      // Reset state with requests pending
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_tx", {23'd0, tx_word}, 32'd0);
      chk("rst_lane", {30'd0, tx_lane_id}, 32'd0);
      chk("rst_pop", {28'd0, pop}, 32'd0);

      // Training then first idle word
      req = 4'h0;
      @(negedge clk);
      reset_L = 1'b1;
      train_up(4'h0, 2'd0);
      cyc(4'h0, 1'b1, 9'h07C, 2'd0, 4'h0, 2'd2);

      // All lanes requesting: burst cap rotates every four grants
      for (int i = 0; i < 17; i++) begin
         l = (i / 4) % 4;
         cyc(4'hF, 1'b1, dw(l), 2'(l), 4'(4'b0001 << l), 2'd2);
      end

      // Single requester is never capped
      data_in2 = 8'hA5;
      for (int i = 0; i < 10; i++) cyc(4'b0100, 1'b1, 9'h1A5, 2'd2, 4'b0100, 2'd2);
      data_in2 = 8'h12;

      // Link loss mid-burst on lane 1
      cyc(4'b0010, 1'b1, 9'h111, 2'd1, 4'b0010, 2'd2);
      cyc(4'b0010, 1'b1, 9'h111, 2'd1, 4'b0010, 2'd2);
      cyc(4'b0010, 1'b0, 9'h1BC, 2'd1, 4'b0000, 2'd1);
      cyc(4'b0010, 1'b1, 9'h1BC, 2'd1, 4'b0000, 2'd1);
      cyc(4'b0010, 1'b1, 9'h1BC, 2'd1, 4'b0000, 2'd1);
      cyc(4'b0010, 1'b1, 9'h1BC, 2'd1, 4'b0000, 2'd2);
      // Arbitration resumes on lane 1 with a fresh burst
      for (int i = 0; i < 4; i++) cyc(4'hF, 1'b1, 9'h111, 2'd1, 4'b0010, 2'd2);
      cyc(4'hF, 1'b1, 9'h112, 2'd2, 4'b0100, 2'd2);

      // Idle holds lane id, pointer and burst count
      cyc(4'h0, 1'b1, 9'h07C, 2'd2, 4'h0, 2'd2);
      cyc(4'hF, 1'b1, 9'h112, 2'd2, 4'b0100, 2'd2);

      // Asynchronous reset pulse between edges
      req     = 4'hF;
      reset_L = 1'b0;
      #1;
      chk("arst_state", {30'd0, state}, 32'd0);
      chk("arst_tx", {23'd0, tx_word}, 32'd0);
      chk("arst_lane", {30'd0, tx_lane_id}, 32'd0);
      chk("arst_pop", {28'd0, pop}, 32'd0);
      #1;
      reset_L = 1'b1;
      train_up(4'hF, 2'd0);
      cyc(4'hF, 1'b1, 9'h110, 2'd0, 4'b0001, 2'd2);

      // Link never locks: training persists with requests pending
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
      cyc(4'hF, 1'b0, 9'h000, 2'd0, 4'h0, 2'd1);
      for (int i = 0; i < 49; i++) cyc(4'hF, 1'b0, 9'h1BC, 2'd0, 4'h0, 2'd1);
      cyc(4'hF, 1'b1, 9'h1BC, 2'd0, 4'h0, 2'd2);
      cyc(4'hF, 1'b1, 9'h110, 2'd0, 4'b0001, 2'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
